hood_mode_ctrl_param: RTL and testbench

- Parametrised successor to the range-hood mode controller.
- Generalises to NUM_LEVELS fan speeds: levels 1..NUM_LEVELS-1 are normal; level NUM_LEVELS is a timed boost that can be used once per power cycle.
- Adds configurable timer lengths, a visible countdown output, and a long-press escape from every powered state.
- Sits between the button debounce/press-classifier and the fan driver and display logic.

---
 rtl/hood_pkg.sv | 27 ++
 rtl/hood_state_timer.sv | 41 ++++
 rtl/hood_mode_ctrl_param.sv | 178 +++++++++++++++++
 tb/tb_hood_mode_ctrl_param.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hood_pkg.sv
// Shared definitions for the parametrised range-hood mode controller.
// Holds the state encoding, the default timing constants and a helper that
// identifies states whose duration is shown on the countdown display.
package hood_pkg;

  // 3'd7 is not a legal state; the controller recovers from it to OFF.
  typedef enum logic [2:0] {
    OFF       = 3'd0,
    STANDBY   = 3'd1,
    MODE_SEL  = 3'd2,
    LEVEL     = 3'd3,
    BOOST     = 3'd4,
    CLEAN     = 3'd5,
    WAIT_STBY = 3'd6
  } state_t;

  localparam longint unsigned DEF_BOOST_TIME = 64'd1000000000;
  localparam longint unsigned DEF_CLEAN_TIME = 64'd1500000000;
  localparam longint unsigned DEF_WAIT_TIME  = 64'd1000000000;
  localparam longint unsigned DEF_IDLE_TIME  = 64'd3000000000;

  // States whose remaining time is shown to the user.
  function automatic logic is_countdown_state(input state_t s);
    return (s == BOOST) || (s == CLEAN) || (s == WAIT_STBY);
  endfunction

endpackage

// File: rtl/hood_state_timer.sv
// Shared state timer for the hood controller.
// Counts cycles spent in the current timed state, flags expiry on the last
// cycle (timer == length-1) and reports the cycles remaining after this one.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart the count at zero on the next edge
//   run       : current state is timed; count advances each cycle
//   length    : duration of the current timed state in cycles (non-zero)
//   expired   : last cycle of the current timed state
//   countdown : length-1-timer while running, 0 otherwise
module hood_state_timer #(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               run,
  input  logic [TIMER_W-1:0] length,
  output logic               expired,
  output logic [TIMER_W-1:0] countdown
);

  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] last;

  assign last = length - TIMER_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (run) begin
      timer <= timer + TIMER_W'(1);
    end
  end

  assign expired   = run && (timer == last);
  assign countdown = run ? (last - timer) : '0;

endmodule

// File: rtl/hood_mode_ctrl_param.sv
// Range-hood mode controller with NUM_LEVELS fan speeds.
// Levels 1..NUM_LEVELS-1 are normal speeds; level NUM_LEVELS is a timed boost
// usable once per power cycle. BOOST, CLEAN and WAIT_STBY are timed states
// whose remaining cycles are shown on countdown.
// Optional build macro HOOD_AUTO_OFF_EN: STANDBY turns the hood off after
// IDLE_TIME cycles without any key pulse (countdown stays hidden there).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   power_short/long  : classified power/menu key pulses
//   level_req, level_idx : level key pulse and requested level 1..NUM_LEVELS
//   clean_req         : self-clean key pulse
//   state             : current state (hood_pkg::state_t encoding)
//   fan_level         : commanded fan speed, 0 = off
//   boost_used        : boost consumed in this power cycle
//   countdown         : cycles remaining in a timed state after this one
//   countdown_active  : high in BOOST, CLEAN and WAIT_STBY
module hood_mode_ctrl_param
  import hood_pkg::*;
#(
  parameter int              NUM_LEVELS = 3,
  parameter int              TIMER_W    = 32,
  parameter longint unsigned BOOST_TIME = DEF_BOOST_TIME,
  parameter longint unsigned CLEAN_TIME = DEF_CLEAN_TIME,
  parameter longint unsigned WAIT_TIME  = DEF_WAIT_TIME,
  parameter longint unsigned IDLE_TIME  = DEF_IDLE_TIME,
  localparam int             LVL_W      = $clog2(NUM_LEVELS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               power_short,
  input  logic               power_long,
  input  logic               level_req,
  input  logic [LVL_W-1:0]   level_idx,
  input  logic               clean_req,
  output logic [2:0]         state,
  output logic [LVL_W-1:0]   fan_level,
  output logic               boost_used,
  output logic [TIMER_W-1:0] countdown,
  output logic               countdown_active
);

  // Durations are truncated to the timer width.
  localparam logic [TIMER_W-1:0] BOOST_T = BOOST_TIME[TIMER_W-1:0];
  localparam logic [TIMER_W-1:0] CLEAN_T = CLEAN_TIME[TIMER_W-1:0];
  localparam logic [TIMER_W-1:0] WAIT_T  = WAIT_TIME[TIMER_W-1:0];
  localparam logic [TIMER_W-1:0] IDLE_T  = IDLE_TIME[TIMER_W-1:0];

  localparam logic [LVL_W-1:0] LV_BOOST = LVL_W'(NUM_LEVELS);
  localparam logic [LVL_W-1:0] LV_TOP   = LVL_W'(NUM_LEVELS - 1);

  if (NUM_LEVELS < 2) begin : g_chk_levels
    $error("hood_mode_ctrl_param: NUM_LEVELS must be at least 2");
  end
  if (BOOST_T == '0 || CLEAN_T == '0 || WAIT_T == '0 || IDLE_T == '0) begin : g_chk_times
    $error("hood_mode_ctrl_param: state durations must be non-zero after truncation");
  end

  state_t             state_q, state_d;
  logic [LVL_W-1:0]   fan_q, fan_d;
  logic               used_q, used_d;
  logic               lvl_normal, lvl_boost, any_pulse;
  logic               tmr_run, tmr_clear, tmr_expired;
  logic [TIMER_W-1:0] tmr_len, tmr_countdown;

  assign lvl_normal = level_req && (level_idx != '0) && (level_idx < LV_BOOST);
  assign lvl_boost  = level_req && (level_idx == LV_BOOST);
  assign any_pulse  = power_short || power_long || level_req || clean_req;

  // Select the duration of the current state; untimed states do not run.
  always_comb begin
    tmr_run = 1'b0;
    tmr_len = '0;
    case (state_q)
      BOOST:     begin tmr_run = 1'b1; tmr_len = BOOST_T; end
      CLEAN:     begin tmr_run = 1'b1; tmr_len = CLEAN_T; end
      WAIT_STBY: begin tmr_run = 1'b1; tmr_len = WAIT_T;  end
`ifdef HOOD_AUTO_OFF_EN
      STANDBY:   begin tmr_run = 1'b1; tmr_len = IDLE_T;  end
`endif
      default:   ;
    endcase
  end

  // Priority: power_long > expiry > power_short > level_req > clean_req.
  // A request that is ignored in the current state does not block a
  // lower-priority request arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    fan_d   = fan_q;
    used_d  = used_q;
    if (power_long && state_q != OFF) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF: begin
          if (power_short) state_d = STANDBY;
        end
        STANDBY: begin
          if (tmr_expired)      state_d = OFF;
          else if (power_short) state_d = MODE_SEL;
        end
        MODE_SEL: begin
          if (lvl_normal) begin
            state_d = LEVEL;
            fan_d   = level_idx;
          end else if (lvl_boost && !used_q) begin
            state_d = BOOST;
          end else if (clean_req) begin
            state_d = CLEAN;
          end
        end
        LEVEL: begin
          if (power_short)     state_d = STANDBY;
          else if (lvl_normal) fan_d   = level_idx;
        end
        BOOST: begin
          if (tmr_expired) begin
            state_d = LEVEL;
            fan_d   = LV_TOP;
          end else if (power_short) begin
            state_d = WAIT_STBY;
          end
        end
        WAIT_STBY: begin
          if (tmr_expired) state_d = STANDBY;
        end
        CLEAN: begin
          if (tmr_expired) state_d = STANDBY;
        end
        default: state_d = OFF;
      endcase
    end

    // Fan speed is fixed by the destination state except inside LEVEL.
    case (state_d)
      OFF, STANDBY, MODE_SEL, CLEAN: fan_d = '0;
      BOOST, WAIT_STBY:              fan_d = LV_BOOST;
      default:                       ;
    endcase

    if (state_d == OFF)   used_d = 1'b0;
    if (state_d == BOOST) used_d = 1'b1;
  end

  // Any key pulse restarts the idle count; it only matters where STANDBY is timed.
  assign tmr_clear = (state_d != state_q) || (state_q == STANDBY && any_pulse);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      fan_q   <= '0;
      used_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fan_q   <= fan_d;
      used_q  <= used_d;
    end
  end

  hood_state_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (tmr_clear),
    .run       (tmr_run),
    .length    (tmr_len),
    .expired   (tmr_expired),
    .countdown (tmr_countdown)
  );

  assign state            = state_q;
  assign fan_level        = fan_q;
  assign boost_used       = used_q;
  assign countdown_active = is_countdown_state(state_q);
  assign countdown        = countdown_active ? tmr_countdown : '0;

endmodule

// File: tb/tb_hood_mode_ctrl_param.sv
// Testbench for hood_mode_ctrl_param with NUM_LEVELS=4, BOOST=10, CLEAN=15,
// WAIT=5 and IDLE=8 (idle timeout only active with HOOD_AUTO_OFF_EN).
module tb_hood_mode_ctrl_param;
  import hood_pkg::*;

  localparam int NL = 4;
  localparam int TW = 16;
  localparam int LW = $clog2(NL + 1);
  localparam int T_BOOST = 10;
  localparam int T_CLEAN = 15;
  localparam int T_WAIT  = 5;
  localparam int T_IDLE  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          power_short, power_long, level_req, clean_req;
  logic [LW-1:0] level_idx;
  logic [2:0]    state;
  logic [LW-1:0] fan_level;
  logic          boost_used;
  logic [TW-1:0] countdown;
  logic          countdown_active;

  int nvec = 0;
  int nerr = 0;

  // Reference model: mode number, fan, boost flag, and cycles left in the
  // current timed stay (including the present cycle; 0 when untimed).
  int m_mode, m_fan, m_left;
  bit m_used;

  always #5 clk = ~clk;

  hood_mode_ctrl_param #(
    .NUM_LEVELS (NL),
    .TIMER_W    (TW),
    .BOOST_TIME (64'(T_BOOST)),
    .CLEAN_TIME (64'(T_CLEAN)),
    .WAIT_TIME  (64'(T_WAIT)),
    .IDLE_TIME  (64'(T_IDLE))
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .power_short      (power_short),
    .power_long       (power_long),
    .level_req        (level_req),
    .level_idx        (level_idx),
    .clean_req        (clean_req),
    .state            (state),
    .fan_level        (fan_level),
    .boost_used       (boost_used),
    .countdown        (countdown),
    .countdown_active (countdown_active)
  );

  function automatic int stay_len(input int mode);
    if (mode == BOOST)     return T_BOOST;
    if (mode == CLEAN)     return T_CLEAN;
    if (mode == WAIT_STBY) return T_WAIT;
`ifdef HOOD_AUTO_OFF_EN
    if (mode == STANDBY)   return T_IDLE;
`endif
    return 0;
  endfunction

  function automatic bit shows_countdown(input int mode);
    return mode == BOOST || mode == CLEAN || mode == WAIT_STBY;
  endfunction

  task automatic model_reset();
    m_mode = OFF; m_fan = 0; m_used = 0; m_left = 0;
  endtask

  task automatic model_step(input bit ps, input bit pl, input bit lr, input int li, input bit cr);
    int  nxt  = m_mode;
    int  fan  = m_fan;
    bit  last = (m_left == 1);
    bit  norm = lr && li >= 1 && li <= NL - 1;
    bit  bst  = lr && li == NL && !m_used;
    if (pl && m_mode != OFF) nxt = OFF;
    else if (last) begin
      if (m_mode == BOOST) begin nxt = LEVEL; fan = NL - 1; end
      else if (m_mode == STANDBY) nxt = OFF;
      else nxt = STANDBY;
    end else if (m_mode == OFF && ps)       nxt = STANDBY;
    else if (m_mode == STANDBY && ps)       nxt = MODE_SEL;
    else if (m_mode == LEVEL && ps)         nxt = STANDBY;
    else if (m_mode == BOOST && ps)         nxt = WAIT_STBY;
    else if (m_mode == MODE_SEL && norm)    begin nxt = LEVEL; fan = li; end
    else if (m_mode == MODE_SEL && bst)     nxt = BOOST;
    else if (m_mode == MODE_SEL && cr)      nxt = CLEAN;
    else if (m_mode == LEVEL && norm)       fan = li;

    if (nxt == BOOST || nxt == WAIT_STBY) fan = NL;
    else if (nxt != LEVEL) fan = 0;
    if (nxt == OFF)   m_used = 0;
    if (nxt == BOOST) m_used = 1;

    if (nxt != m_mode) m_left = stay_len(nxt);
    else if (nxt == STANDBY && (ps || pl || lr || cr)) m_left = stay_len(nxt);
    else if (m_left > 0) m_left = m_left - 1;
    m_mode = nxt;
    m_fan  = fan;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit act = shows_countdown(m_mode);
    chk("state", 32'(state), 32'(m_mode));
    chk("fan_level", 32'(fan_level), 32'(m_fan));
    chk("boost_used", 32'(boost_used), 32'(m_used));
    chk("countdown", 32'(countdown), act ? 32'(m_left - 1) : 32'd0);
    chk("countdown_active", 32'(countdown_active), 32'(act));
  endtask

  task automatic step(input bit ps, input bit pl, input bit lr, input int li, input bit cr);
    @(negedge clk);
    power_short = ps; power_long = pl; level_req = lr;
    level_idx = LW'(li); clean_req = cr;
    @(posedge clk);
    model_step(ps, pl, lr, li, cr);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    power_short = 0; power_long = 0; level_req = 0; clean_req = 0; level_idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_state", 32'(state), 32'(OFF));
    @(negedge clk);
    rst = 1'b0;

    // Power-up and level changes
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 2, 0);
    chk("pu_state", 32'(state), 32'(LEVEL));
    chk("pu_fan2", 32'(fan_level), 32'd2);
    step(0, 0, 1, 3, 0);
    chk("pu_fan3", 32'(fan_level), 32'd3);

    // Invalid requests in MODE_SEL, then a full boost
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 5, 0);
    chk("invalid_idx", 32'(state), 32'(MODE_SEL));
    step(0, 0, 1, 4, 0);
    chk("boost_cd_first", 32'(countdown), 32'd9);
    idle(T_BOOST - 1);
    chk("boost_cd_last", 32'(countdown), 32'd0);
    idle(1);
    chk("boost_drop_state", 32'(state), 32'(LEVEL));
    chk("boost_drop_fan", 32'(fan_level), 32'd3);
    chk("boost_drop_used", 32'(boost_used), 32'd1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 4, 0);
    chk("boost_reuse", 32'(state), 32'(MODE_SEL));

    // Fresh power cycle, boost interrupted by a short press
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 4, 0);
    idle(2);
    step(1, 0, 0, 0, 0);
    chk("wait_fan", 32'(fan_level), 32'(NL));
    idle(T_WAIT - 1);
    chk("wait_hold", 32'(state), 32'(WAIT_STBY));
    idle(1);
    chk("wait_end", 32'(state), 32'(STANDBY));

    // power_long out of WAIT_STBY
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 4, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("long_wait_used", 32'(boost_used), 32'd0);

    // Short press on the boost expiry cycle
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 4, 0);
    idle(T_BOOST - 1);
    step(1, 0, 0, 0, 0);
    chk("expiry_wins", 32'(state), 32'(LEVEL));

    // Clean cycle, then async reset mid-clean
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(T_CLEAN - 1);
    chk("clean_hold", 32'(state), 32'(CLEAN));
    idle(1);
    chk("clean_end", 32'(state), 32'(STANDBY));
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_state", 32'(state), 32'(OFF));
    chk("async_rst_cd", 32'(countdown), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle in STANDBY (times out only with the auto-off build)
    step(1, 0, 0, 0, 0);
    idle(T_IDLE);
    step(0, 0, 0, 0, 0);
    if (m_mode == OFF) step(1, 0, 0, 0, 0);
    idle(5);
    step(0, 0, 0, 0, 1);
    idle(T_IDLE);

    // Randomized traffic
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 6) == 0, ($urandom % 60) == 0, ($urandom % 4) == 0,
           int'($urandom % (NL + 2)), ($urandom % 8) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
